// File: rtl/pulse_stretcher.sv
// Turns every rising edge on event_i into one TIME_ON-cycle high pulse followed by a
// TIME_OFF-cycle low gap; edges arriving meanwhile are queued in a saturating counter.
`ifndef CONTA_1S
`define CONTA_1S 50000000
`endif

module pulse_stretcher #(
  parameter int unsigned TIME_ON    = `CONTA_1S,
  parameter int unsigned TIME_OFF   = `CONTA_1S,
  parameter int unsigned PEND_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  event_i,
  output logic                  signal_o,
  output logic                  busy_o,
  output logic [PEND_WIDTH-1:0] pending_o,
  output logic                  overflow_o
);

  typedef enum logic [1:0] {
    ST_PS_IDLE = 2'd0,
    ST_PS_ON   = 2'd1,
    ST_PS_OFF  = 2'd2
  } state_t;

  localparam logic [31:0]           ON_LAST  = 32'(TIME_ON - 1);
  localparam logic [31:0]           OFF_LAST = 32'(TIME_OFF - 1);
  localparam logic [PEND_WIDTH-1:0] PEND_MAX = {PEND_WIDTH{1'b1}};
  localparam logic [PEND_WIDTH-1:0] PEND_ONE = PEND_WIDTH'(1);

  state_t                  state_q, state_d;
  logic [31:0]             cnt_q, cnt_d;
  logic [PEND_WIDTH-1:0]   pend_q, pend_d;
  logic                    ovf_q, ovf_d;
  logic                    event_q;
  logic                    edge_w;
  logic                    queue_w;

  assign edge_w = event_i & ~event_q;

  // Register stage: all state here is control, so everything is reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_PS_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      event_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      event_q <= event_i;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    queue_w = 1'b0;
    case (state_q)
      ST_PS_IDLE: begin
        if (edge_w) begin
          state_d = ST_PS_ON;
          cnt_d   = '0;
        end
      end
      ST_PS_ON: begin
        queue_w = edge_w;
        if (cnt_q == ON_LAST) begin
          state_d = ST_PS_OFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_PS_OFF: begin
        if (cnt_q == OFF_LAST) begin
          cnt_d = '0;
          if (pend_q != '0) begin
            // A same-cycle edge replaces the one being dequeued: net zero.
            state_d = ST_PS_ON;
            if (!edge_w) pend_d = pend_q - PEND_ONE;
          end else if (edge_w) begin
            state_d = ST_PS_ON;
          end else begin
            state_d = ST_PS_IDLE;
          end
        end else begin
          cnt_d   = cnt_q + 32'd1;
          queue_w = edge_w;
        end
      end
      default: begin
        state_d = ST_PS_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (queue_w) begin
      if (pend_q == PEND_MAX) ovf_d = 1'b1;
      else                    pend_d = pend_q + PEND_ONE;
    end
  end

  assign signal_o   = (state_q == ST_PS_ON);
  assign busy_o     = (state_q != ST_PS_IDLE);
  assign pending_o  = pend_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher with TIME_ON=4, TIME_OFF=2, PEND_WIDTH=2.
module tb_pulse_stretcher;

  logic       clk = 1'b0;
  logic       rst;
  logic       ev;
  logic       sig;
  logic       busy;
  logic [1:0] pend;
  logic       ovf;

  int tests = 0;
  int fails = 0;
  int pulses;
  logic prev_sig;

  pulse_stretcher #(
    .TIME_ON   (4),
    .TIME_OFF  (2),
    .PEND_WIDTH(2)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .event_i   (ev),
    .signal_o  (sig),
    .busy_o    (busy),
    .pending_o (pend),
    .overflow_o(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       e;
    logic       s;
    logic       b;
    logic [1:0] p;
    logic       o;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int n, input logic r, input logic e, input logic s,
                     input logic b, input logic [1:0] p, input logic o);
    vec_t v;
    v.r = r; v.e = e; v.s = s; v.b = b; v.p = p; v.o = o;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: apply inputs, let the edge happen, sample 1 ns later.
  task automatic cyc(input logic r, input logic e);
    rst = r;
    ev  = e;
    @(posedge clk);
    #1;
    if (sig === 1'b1 && prev_sig !== 1'b1) pulses++;
    prev_sig = sig;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic ovf_stuck;
    logic sig_seen;
    rst = 1'b1;
    ev  = 1'b0;
    prev_sig = 1'b0;
    pulses = 0;

    // reset then idle
    add(2, 1, 0, 0, 0, 0, 0);
    add(20, 0, 0, 0, 0, 0, 0);
    // single one-cycle event
    add(1, 0, 1, 1, 1, 0, 0);
    add(3, 0, 0, 1, 1, 0, 0);
    add(2, 0, 0, 0, 1, 0, 0);
    add(3, 0, 0, 0, 0, 0, 0);
    // held level gives one pulse only
    add(4, 0, 1, 1, 1, 0, 0);
    add(2, 0, 1, 0, 1, 0, 0);
    add(24, 0, 1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0);
    // queueing: edges at cycles 1,3,5,7,9; cycle 7 lands on end-of-OFF (net zero)
    add(1, 0, 1, 1, 1, 0, 0);
    add(1, 0, 0, 1, 1, 0, 0);
    add(1, 0, 1, 1, 1, 1, 0);
    add(1, 0, 0, 1, 1, 1, 0);
    add(1, 0, 1, 0, 1, 2, 0);
    add(1, 0, 0, 0, 1, 2, 0);
    add(1, 0, 1, 1, 1, 2, 0);
    add(1, 0, 0, 1, 1, 2, 0);
    add(1, 0, 1, 1, 1, 3, 0);
    add(1, 0, 0, 1, 1, 3, 0);
    add(2, 0, 0, 0, 1, 3, 0);
    add(4, 0, 0, 1, 1, 2, 0);
    add(2, 0, 0, 0, 1, 2, 0);
    add(4, 0, 0, 1, 1, 1, 0);
    add(2, 0, 0, 0, 1, 1, 0);
    add(4, 0, 0, 1, 1, 0, 0);
    add(2, 0, 0, 0, 1, 0, 0);
    add(2, 0, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].e);
      check($sformatf("vec%0d {sig,busy,pend,ovf}", i),
            int'({sig, busy, pend, ovf}),
            int'({tbl[i].s, tbl[i].b, tbl[i].p, tbl[i].o}));
    end

    // Overflow: sixth edge arrives with the queue full and is dropped.
    cyc(1, 0);
    cyc(1, 0);
    pulses = 0;
    cyc(0, 1);
    cyc(0, 0);
    cyc(0, 1);  check("ovf_pend1", int'(pend), 1);
    cyc(0, 0);
    cyc(0, 1);  check("ovf_pend2", int'(pend), 2);
    cyc(0, 0);
    cyc(0, 1);  check("ovf_netzero_pend", int'(pend), 2);
                check("ovf_netzero_sig", int'(sig), 1);
    cyc(0, 0);
    cyc(0, 1);  check("ovf_pend3", int'(pend), 3);
                check("ovf_not_yet", int'(ovf), 0);
    cyc(0, 0);
    cyc(0, 1);  check("ovf_sat_pend", int'(pend), 3);
                check("ovf_set", int'(ovf), 1);
    ovf_stuck = 1'b1;
    for (int i = 0; i < 25; i++) begin
      cyc(0, 0);
      if (ovf !== 1'b1) ovf_stuck = 1'b0;
    end
    check("ovf_sticky", int'(ovf_stuck), 1);
    check("ovf_drained_busy", int'(busy), 0);
    check("ovf_drained_pend", int'(pend), 0);
    check("ovf_pulse_count", pulses, 5);

    // Reset on the second high cycle of a pulse with two events queued.
    cyc(0, 1);
    cyc(0, 0);
    cyc(0, 1);
    cyc(0, 0);
    cyc(0, 1);
    cyc(0, 0);
    cyc(0, 1);
    cyc(0, 0);  check("rmid_pre_sig", int'(sig), 1);
                check("rmid_pre_pend", int'(pend), 2);
    cyc(1, 0);  check("rmid_sig", int'(sig), 0);
                check("rmid_busy", int'(busy), 0);
                check("rmid_pend", int'(pend), 0);
                check("rmid_ovf_cleared", int'(ovf), 0);
    sig_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0);
      if (sig !== 1'b0 || busy !== 1'b0) sig_seen = 1'b1;
    end
    check("rmid_no_more_pulses", int'(sig_seen), 0);

    // A level already high on the first cycle after reset counts as an event.
    cyc(1, 1);
    cyc(0, 1);  check("post_rst_level_sig", int'(sig), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
